// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter shared by instruction fetch (IF) and load/store (LS).
// LS has priority. A starvation counter hands the next arbitration to IF after
// STARVE_MAX consecutive IF denials. One transaction is in flight at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no transaction; combinational arbitration, grant same cycle
// BUSY_IF | IF read in flight, mem_req_o held until ack or timeout
// BUSY_LS | LS read/write in flight, mem_req_o held until ack or timeout
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        bus_err_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;

  logic idle;
  logic if_starved;
  logic ls_win;
  logic if_win;
  logic to_hit;

  // Arbitration is combinational in IDLE so a requester sees its grant in the request cycle.
  always_comb begin
    idle       = (state == IDLE) && !rst_i;
    if_starved = (starve_cnt == SW'(STARVE_MAX));
    ls_win     = idle && ls_req_i && !(if_req_i && if_starved);
    if_win     = idle && if_req_i && !ls_win;
    // Down-counter loaded with TIMEOUT at grant; terminal count 1 is the last allowed cycle.
    to_hit     = (TIMEOUT != 0) && (to_cnt == TW'(1));
  end

  assign ls_gnt_o = ls_win;
  assign if_gnt_o = if_win;

  // Starvation counter: counts IF denials in IDLE, saturates, clears on IF grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (if_win) begin
      starve_cnt <= '0;
    end else if (idle && if_req_i && !if_starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Main FSM: latches the winning request, holds the memory bus, returns the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      to_cnt      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      ls_rvalid_o <= 1'b0;
      ls_rdata_o  <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      ls_rvalid_o <= 1'b0;
      ls_rdata_o  <= '0;
      bus_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (ls_win) begin
            state       <= BUSY_LS;
            mem_req_o   <= 1'b1;
            mem_we_o    <= ls_we_i;
            mem_be_o    <= ls_be_i;
            mem_addr_o  <= ls_addr_i;
            mem_wdata_o <= ls_wdata_i;
            to_cnt      <= TW'(TIMEOUT);
          end else if (if_win) begin
            state       <= BUSY_IF;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'hF;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            to_cnt      <= TW'(TIMEOUT);
          end
        end
        BUSY_IF, BUSY_LS: begin
          if (mem_ack_i || to_hit) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            to_cnt      <= '0;
            // An ack in the terminal cycle still counts as a normal completion.
            bus_err_o   <= !mem_ack_i;
            if (state == BUSY_IF) begin
              if_rvalid_o <= 1'b1;
              if_rdata_o  <= mem_ack_i ? mem_rdata_i : '0;
            end else begin
              ls_rvalid_o <= 1'b1;
              ls_rdata_o  <= (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
            end
          end else if (TIMEOUT != 0) begin
            to_cnt <= to_cnt - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random and directed requester traffic, a memory
// agent with random ack latency, and a reference model of arbitration and memory contents.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  int checks   = 0;
  int failures = 0;

  resp_t       if_q[$];
  resp_t       ls_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] agt_mem[logic [31:0]];

  // requester state
  bit          if_pend = 0, ls_pend = 0;
  logic [31:0] if_a, ls_a, ls_wd;
  logic        ls_w;
  logic [3:0]  ls_b;

  // reference model state
  bit          m_busy = 0, m_owner_ls = 0;
  int          m_starve = 0, m_hi = 0, ack_delay = 0;
  logic        exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata;
  bit          exp_if_rv = 0, exp_ls_rv = 0, exp_err = 0, exp_zero = 1;

  // agent / scenario controls
  bit rst_req = 1, no_ack = 0, late_ack = 0, spurious_en = 0;
  int fixed_delay = -1;
  int ls_wait = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] agt_rd(logic [31:0] a);
    return agt_mem.exists(a) ? agt_mem[a] : init_word(a);
  endfunction

  task automatic new_if(logic [31:0] a);
    if_pend = 1; if_a = a; ls_wait = 0;
  endtask

  task automatic new_ls(logic we, logic [3:0] be, logic [31:0] a, logic [31:0] wd);
    ls_pend = 1; ls_w = we; ls_b = be; ls_a = a; ls_wd = wd;
  endtask

  task automatic finish_txn(bit err);
    m_busy = 0;
    if (m_owner_ls) exp_ls_rv = 1; else exp_if_rv = 1;
    exp_err = err;
  endtask

  // One clock cycle: observe registered outputs at the falling edge, play the memory agent,
  // drive requests, then check the combinational grants against the model's arbitration.
  task automatic step();
    bit    busy_now, g_if, g_ls;
    resp_t r;
    @(negedge clk);
    if (exp_zero) begin
      check("reset_mem_bus", 128'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 128'(0));
      check("reset_resp", 128'({if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o, bus_err_o}), 128'(0));
      exp_zero = 0;
    end
    check("if_rvalid_o", 128'(if_rvalid_o), 128'(exp_if_rv));
    check("ls_rvalid_o", 128'(ls_rvalid_o), 128'(exp_ls_rv));
    check("bus_err_o", 128'(bus_err_o), 128'(exp_err));
    exp_if_rv = 0; exp_ls_rv = 0; exp_err = 0;
    busy_now = m_busy;

    rst_i       = rst_req;
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom();
    if (busy_now) begin
      m_hi++;
      check("mem_req_o_busy", 128'(mem_req_o), 128'(1));
      check("mem_ctrl", 128'({mem_we_o, mem_be_o, mem_addr_o}), 128'({exp_we, exp_be, exp_addr}));
      if (exp_we) check("mem_wdata_o", 128'(mem_wdata_o), 128'(exp_wdata));
    end else begin
      check("mem_req_o_idle", 128'(mem_req_o), 128'(0));
    end

    if (rst_req) begin
      if (busy_now) begin
        if (m_owner_ls) void'(ls_q.pop_back()); else void'(if_q.pop_back());
      end
      m_busy = 0; m_starve = 0; late_ack = 0; exp_zero = 1;
    end else if (busy_now) begin
      if (!no_ack && m_hi == ack_delay + 1) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) agt_mem[mem_addr_o] = merge(agt_rd(mem_addr_o), mem_wdata_o, mem_be_o);
        else mem_rdata_i = agt_rd(mem_addr_o);
        finish_txn(0);
      end else if (m_hi == TIMEOUT) begin
        finish_txn(1);
        late_ack = no_ack;
      end
    end else if (late_ack || (spurious_en && $urandom_range(0, 7) == 0)) begin
      mem_ack_i = 1'b1;
      late_ack  = 0;
    end

    if_req_i   = if_pend;
    if_addr_i  = if_pend ? if_a : $urandom();
    ls_req_i   = ls_pend;
    ls_we_i    = ls_pend ? ls_w : 1'b0;
    ls_be_i    = ls_pend ? ls_b : 4'($urandom());
    ls_addr_i  = ls_pend ? ls_a : $urandom();
    ls_wdata_i = ls_pend ? ls_wd : $urandom();

    #1;
    g_ls = !busy_now && !rst_req && ls_pend && !(if_pend && m_starve == STARVE_MAX);
    g_if = !busy_now && !rst_req && if_pend && !g_ls;
    check("ls_gnt_o", 128'(ls_gnt_o), 128'(g_ls));
    check("if_gnt_o", 128'(if_gnt_o), 128'(g_if));
    if (ls_gnt_o && if_pend) ls_wait++;
    if (if_gnt_o) begin
      check("if_wait_bound", 128'(ls_wait <= STARVE_MAX + 1), 128'(1));
      ls_wait = 0;
    end

    if (!busy_now && !rst_req) begin
      if (g_if) m_starve = 0;
      else if (if_pend && m_starve < STARVE_MAX) m_starve++;
      if (g_ls || g_if) begin
        m_busy = 1; m_hi = 0; m_owner_ls = g_ls;
        ack_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
      end
      if (g_ls) begin
        exp_we = ls_w; exp_be = ls_b; exp_addr = ls_a; exp_wdata = ls_wd;
        if (no_ack) r = '{data: 32'h0, err: 1'b1};
        else if (ls_w) begin
          ref_mem[ls_a] = merge(ref_rd(ls_a), ls_wd, ls_b);
          r = '{data: 32'h0, err: 1'b0};
        end else r = '{data: ref_rd(ls_a), err: 1'b0};
        ls_q.push_back(r);
        ls_pend = 0;
      end else if (g_if) begin
        exp_we = 1'b0; exp_be = 4'hF; exp_addr = if_a; exp_wdata = 32'h0;
        if (no_ack) r = '{data: 32'h0, err: 1'b1};
        else r = '{data: ref_rd(if_a), err: 1'b0};
        if_q.push_back(r);
        if_pend = 0;
      end
    end
  endtask

  task automatic wait_idle(int max);
    int n = 0;
    while ((if_pend || ls_pend || m_busy || late_ack || exp_if_rv || exp_ls_rv) && n < max) begin
      step();
      n++;
    end
    if (n >= max) begin
      checks++; failures++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT presents a completion.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid_o) begin
        if (if_q.size() == 0) check("if_unexpected_rvalid", 128'(1), 128'(0));
        else begin
          e = if_q.pop_front();
          check("if_resp", 128'({if_rdata_o, bus_err_o}), 128'({e.data, e.err}));
        end
      end
      if (ls_rvalid_o) begin
        if (ls_q.size() == 0) check("ls_unexpected_rvalid", 128'(1), 128'(0));
        else begin
          e = ls_q.pop_front();
          check("ls_resp", 128'({ls_rdata_o, bus_err_o}), 128'({e.data, e.err}));
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0; ls_req_i = 1'b0; ls_we_i = 1'b0;
    ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    rst_req = 1;
    repeat (3) step();
    rst_req = 0;
    step();

    // IF read of 0x100, ack one cycle after mem_req_o rises
    fixed_delay = 1;
    new_if(32'h100);
    wait_idle(40);

    // simultaneous requests: LS read of 0x200 wins, IF follows in the LS rvalid cycle
    fixed_delay = 0;
    new_if(32'h104);
    new_ls(1'b0, 4'hF, 32'h200, 32'h0);
    wait_idle(40);

    // LS partial write then read-back
    fixed_delay = 2;
    new_ls(1'b1, 4'b0011, 32'h200, 32'hDEADBEEF);
    wait_idle(40);
    new_ls(1'b0, 4'hF, 32'h200, 32'h0);
    wait_idle(40);

    // random mixed traffic with spurious idle acks
    fixed_delay = -1;
    spurious_en = 1;
    for (int i = 0; i < 600; i++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) new_if(32'($urandom_range(0, 15)));
      if (!ls_pend && $urandom_range(0, 2) == 0)
        new_ls(1'($urandom()), 4'($urandom()), 32'($urandom_range(0, 15)), $urandom());
      step();
    end
    wait_idle(60);

    // both requesters saturated: starvation counter must hand IF the bus
    for (int i = 0; i < 200; i++) begin
      if (!if_pend) new_if(32'($urandom_range(0, 15)));
      if (!ls_pend) new_ls(1'($urandom()), 4'($urandom()), 32'($urandom_range(0, 15)), $urandom());
      step();
    end
    wait_idle(60);
    spurious_en = 0;

    // timeouts with no ack, followed by a late ack that must be ignored
    no_ack = 1;
    new_if(32'h40);
    wait_idle(40);
    new_ls(1'b1, 4'hF, 32'h3, 32'h12345678);
    wait_idle(40);
    no_ack = 0;
    new_ls(1'b0, 4'hF, 32'h3, 32'h0);
    wait_idle(40);

    // reset while LS holds the memory bus, then a normal IF read
    no_ack = 1;
    new_ls(1'b0, 4'hF, 32'h5, 32'h0);
    for (int n = 0; n < 20 && !(m_busy && m_hi >= 2); n++) step();
    check("busy_before_reset", 128'(m_busy && m_owner_ls), 128'(1));
    rst_req = 1;
    step();
    rst_req = 0;
    no_ack  = 0;
    fixed_delay = 0;
    new_if(32'h5);
    wait_idle(40);
    repeat (3) step();

    check("if_q_drained", 128'(if_q.size()), 128'(0));
    check("ls_q_drained", 128'(ls_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
